i2c_protocol: RTL and testbench

- Single-master I2C write engine for configuring an external serial-control peripheral, such as an audio codec register port.
- On `start`, it issues a START condition, a 7-bit address plus R/W bit, then two data bytes (`data_st`, then `data_nd`), checking the ACK after each byte. It finishes with a STOP condition.
- It drives open-drain `sclk`/`sdin` and reports progress through `busy`/`done`.

---
 rtl/i2c_protocol.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_protocol.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_protocol.sv
// Single-master I2C write engine: START, {addr,wr_rd}, two data bytes with ACK checks, STOP.
// Latency: (4 + 27*4 + 4) * QTR_CYCLES clk from start acceptance to the done pulse when all ACKs arrive.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, NACK shortens to STOP.
module i2c_protocol #(
    parameter int QTR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       wr_rd,
    input  logic [7:0] data_st,
    input  logic [7:0] data_nd,
    output logic       busy,
    output logic       done,
    inout  wire        sclk,
    inout  wire        sdin
);

    localparam int CW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK1,
        S_DATA1,
        S_ACK2,
        S_DATA2,
        S_ACK3,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    hdr_q, hdr_d;
    logic [7:0]    d1_q, d1_d;
    logic [7:0]    d2_q, d2_d;
    logic          nack_q, nack_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          scl_q, scl_d;
    logic          sda_q, sda_d;

    logic          tick;
    logic          slot_end;
    logic          sda_rx;
    logic [7:0]    tx_byte;
    logic          tx_bit;

    assign tick     = (cnt_q == CW'(QTR_CYCLES - 1));
    assign slot_end = tick && (qtr_q == 2'd3);
    // Anything other than a hard 0 on the wire counts as a released (1) bit.
    assign sda_rx   = (sdin === 1'b0) ? 1'b0 : 1'b1;

    // Next-state, quarter timing and the line levels belonging to the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        hdr_d   = hdr_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        nack_d  = nack_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tx_byte = 8'hFF;
        tx_bit  = 1'b1;
        scl_d   = 1'b1;
        sda_d   = 1'b1;

        if (busy_q) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                qtr_d = qtr_q + 2'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_START;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    qtr_d   = 2'd0;
                    bit_d   = 3'd0;
                    nack_d  = 1'b0;
                    hdr_d   = {addr, wr_rd};
                    d1_d    = data_st;
                    d2_d    = data_nd;
                end
            end
            S_START: begin
                if (slot_end) begin
                    state_d = S_ADDR;
                    bit_d   = 3'd0;
                end
            end
            S_ADDR, S_DATA1, S_DATA2: begin
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        case (state_q)
                            S_ADDR:  state_d = S_ACK1;
                            S_DATA1: state_d = S_ACK2;
                            default: state_d = S_ACK3;
                        endcase
                    end
                end
            end
            S_ACK1, S_ACK2, S_ACK3: begin
                // Sample the slave's answer on the first clk after SCL goes high.
                if (qtr_q == 2'd2 && cnt_q == '0) begin
                    nack_d = sda_rx;
                end
                if (slot_end) begin
                    bit_d = 3'd0;
                    if (nack_q || state_q == S_ACK3 || (state_q == S_ACK1 && hdr_q[0])) begin
                        state_d = S_STOP;
                    end else if (state_q == S_ACK1) begin
                        state_d = S_DATA1;
                    end else begin
                        state_d = S_DATA2;
                    end
                end
            end
            S_STOP: begin
                if (slot_end) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    qtr_d   = 2'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_ADDR:  tx_byte = hdr_d;
            S_DATA1: tx_byte = d1_d;
            S_DATA2: tx_byte = d2_d;
            default: tx_byte = 8'hFF;
        endcase
        tx_bit = tx_byte[3'd7 - bit_d];

        case (state_d)
            S_START: begin
                scl_d = 1'b1;
                sda_d = ~qtr_d[1];
            end
            S_ADDR, S_DATA1, S_DATA2: begin
                scl_d = qtr_d[1];
                sda_d = tx_bit;
            end
            S_ACK1, S_ACK2, S_ACK3: begin
                scl_d = qtr_d[1];
                sda_d = 1'b1;
            end
            S_STOP: begin
                scl_d = (qtr_d != 2'd0);
                sda_d = (qtr_d == 2'd3);
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    // State register with synchronous reset; reset releases both lines at once.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            qtr_q   <= 2'd0;
            bit_q   <= 3'd0;
            hdr_q   <= 8'h00;
            d1_q    <= 8'h00;
            d2_q    <= 8'h00;
            nack_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            hdr_q   <= hdr_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            nack_q  <= nack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sclk = scl_q ? 1'bz : 1'b0;
    assign sdin = sda_q ? 1'bz : 1'b0;

endmodule

// File: tb/tb_i2c_protocol.sv
// Directed bench for i2c_protocol: pull-ups, an ACKing slave and a bus monitor decoding START/bytes/STOP.
// Latency: transaction lengths are checked against hand-computed quarter counts.
// Backpressure: covers start-while-busy, NACK early STOP and reset abort.
module tb_i2c_protocol;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [6:0] addr;
    logic       wr_rd;
    logic [7:0] data_st;
    logic [7:0] data_nd;
    logic       busy;
    logic       done;
    wire        sclk;
    wire        sdin;

    pullup pu_scl (sclk);
    pullup pu_sda (sdin);

    logic slv_drv;
    logic ack_en;
    assign sdin = slv_drv ? 1'b0 : 1'bz;

    i2c_protocol #(.QTR_CYCLES(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .addr    (addr),
        .wr_rd   (wr_rd),
        .data_st (data_st),
        .data_nd (data_nd),
        .busy    (busy),
        .done    (done),
        .sclk    (sclk),
        .sdin    (sdin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bus monitor / slave state
    logic [7:0] bytes_q[$];
    logic       acks_q[$];
    int         start_cnt = 0;
    int         stop_cnt  = 0;
    int         done_cnt  = 0;
    logic       m_scl, m_sda, s_now, d_now;
    logic [7:0] m_sh;
    int         m_bits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples the bus each falling clk: START/STOP on SDA edges with SCL high, data on SCL rise.
    initial begin
        m_scl   = 1'b1;
        m_sda   = 1'b1;
        m_sh    = 8'h00;
        m_bits  = 0;
        slv_drv = 1'b0;
        forever begin
            @(negedge clk);
            s_now = (sclk !== 1'b0);
            d_now = (sdin !== 1'b0);
            if (done === 1'b1) done_cnt++;
            if (m_scl && s_now && m_sda && !d_now) begin
                start_cnt++;
                m_bits = 0;
            end else if (m_scl && s_now && !m_sda && d_now) begin
                stop_cnt++;
                m_bits = 0;
            end else if (!m_scl && s_now) begin
                if (m_bits == 8) begin
                    bytes_q.push_back(m_sh);
                    acks_q.push_back(d_now);
                    m_bits = 0;
                end else begin
                    m_sh = {m_sh[6:0], d_now};
                    m_bits++;
                end
            end else if (m_scl && !s_now) begin
                slv_drv = ack_en && (m_bits == 8);
            end
            m_scl = s_now;
            m_sda = d_now;
        end
    end

    int n_cyc;
    int b_base, s_base, p_base, d_base;

    // Pulses start for one clk, then waits (bounded) for done; optionally re-pulses start mid-flight.
    task automatic run_txn(input logic [6:0] a, input logic rw, input logic [7:0] x, input logic [7:0] y,
                           input int inject, output int cycles);
        logic got;
        logic busy_drop;
        int   n;
        b_base = bytes_q.size();
        s_base = start_cnt;
        p_base = stop_cnt;
        d_base = done_cnt;
        @(negedge clk);
        addr = a; wr_rd = rw; data_st = x; data_nd = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; got = 1'b0; busy_drop = 1'b0;
        while (!got && n < 2000) begin
            if (inject > 0 && n == inject) begin
                addr = 7'h0F; data_st = 8'h00; data_nd = 8'hFF; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_drop = 1'b1;
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1'b1);
        chk("busy_held", busy_drop, 1'b0);
        chk("busy_low_at_done", busy, 1'b0);
        @(negedge clk);
        chk("done_one_clk", done, 1'b0);
        cycles = n;
    endtask

    initial begin
        reset_n = 1'b1; start = 1'b1; addr = 7'h00; wr_rd = 1'b0;
        data_st = 8'h00; data_nd = 8'h00; ack_en = 1'b1;

        // Reset held with start asserted: nothing may move.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_scl", sclk, 1'b1);
            chk("rst_sda", sdin, 1'b1);
        end
        reset_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // Write with ACK: 116 quarters * 3 clk = 348.
        ack_en = 1'b1;
        run_txn(7'h55, 1'b0, 8'hA5, 8'h5A, 0, n_cyc);
        chk("wr_len", (n_cyc >= 346 && n_cyc <= 350), 1'b1);
        chk("wr_nbytes", bytes_q.size() - b_base, 3);
        chk("wr_b0", bytes_q[b_base], 8'hAA);
        chk("wr_b1", bytes_q[b_base + 1], 8'hA5);
        chk("wr_b2", bytes_q[b_base + 2], 8'h5A);
        chk("wr_acks", {acks_q[b_base], acks_q[b_base + 1], acks_q[b_base + 2]}, 3'b000);
        chk("wr_start", start_cnt - s_base, 1);
        chk("wr_stop", stop_cnt - p_base, 1);
        chk("wr_dones", done_cnt - d_base, 1);
        chk("wr_idle_scl", sclk, 1'b1);
        chk("wr_idle_sda", sdin, 1'b1);

        // NACK on address: START + 0xAA + NACK + STOP, (4+36+4)*3 = 132 clk.
        ack_en = 1'b0;
        run_txn(7'h55, 1'b0, 8'hA5, 8'h5A, 0, n_cyc);
        chk("nack_len", (n_cyc >= 130 && n_cyc <= 134), 1'b1);
        chk("nack_nbytes", bytes_q.size() - b_base, 1);
        chk("nack_b0", bytes_q[b_base], 8'hAA);
        chk("nack_ack", acks_q[b_base], 1'b1);
        chk("nack_stop", stop_cnt - p_base, 1);
        chk("nack_dones", done_cnt - d_base, 1);

        // Read probe: {7'h1A,1} = 0x35, ACKed, then STOP.
        ack_en = 1'b1;
        run_txn(7'h1A, 1'b1, 8'hC3, 8'h3C, 0, n_cyc);
        chk("rd_len", (n_cyc >= 130 && n_cyc <= 134), 1'b1);
        chk("rd_nbytes", bytes_q.size() - b_base, 1);
        chk("rd_b0", bytes_q[b_base], 8'h35);
        chk("rd_ack", acks_q[b_base], 1'b0);
        chk("rd_stop", stop_cnt - p_base, 1);

        // Start while busy plus inputs changing after acceptance: no effect.
        run_txn(7'h55, 1'b0, 8'hA5, 8'h5A, 100, n_cyc);
        repeat (10) @(negedge clk);
        chk("bb_len", (n_cyc >= 346 && n_cyc <= 350), 1'b1);
        chk("bb_nbytes", bytes_q.size() - b_base, 3);
        chk("bb_b0", bytes_q[b_base], 8'hAA);
        chk("bb_b1", bytes_q[b_base + 1], 8'hA5);
        chk("bb_b2", bytes_q[b_base + 2], 8'h5A);
        chk("bb_start", start_cnt - s_base, 1);
        chk("bb_dones", done_cnt - d_base, 1);

        // Reset during DATA1 (clk 120..215 after acceptance).
        d_base = done_cnt;
        @(negedge clk);
        addr = 7'h55; wr_rd = 1'b0; data_st = 8'hA5; data_nd = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (150) @(negedge clk);
        chk("mid_busy_pre", busy, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_scl", sclk, 1'b1);
        chk("abort_sda", sdin, 1'b1);
        chk("abort_busy", busy, 1'b0);
        reset_n = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_cnt - d_base, 0);
        chk("abort_idle", busy, 1'b0);

        run_txn(7'h55, 1'b0, 8'hA5, 8'h5A, 0, n_cyc);
        chk("post_len", (n_cyc >= 346 && n_cyc <= 350), 1'b1);
        chk("post_nbytes", bytes_q.size() - b_base, 3);
        chk("post_b0", bytes_q[b_base], 8'hAA);
        chk("post_b1", bytes_q[b_base + 1], 8'hA5);
        chk("post_b2", bytes_q[b_base + 2], 8'h5A);
        chk("post_dones", done_cnt - d_base, 1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
